// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and width helper for the synchronous FIFO family
//  RD_LATENCY  cycles from FIFO read strobe to data valid
//  clog2       ceiling log2, used to size level counters and buffer indices
package fifo_pkg;
   localparam int RD_LATENCY = 1;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
endpackage

// File: rtl/fifo_rd_stream_adapter_stream_buf.sv
// stream_buf: circular register buffer with push/pop and occupancy count
//  i_clk, i_rst_n  clock, async active-low reset
//  i_flush         clears indices and level next cycle
//  i_push, i_data  write i_data at tail
//  i_pop           advance head
//  o_data          head word; holds last shown word while empty
//  o_level         words currently stored
module stream_buf
   import fifo_pkg::*;
#(
   parameter int SIZE_DATA = 8,
   parameter int BUF_DEPTH = 2
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_flush,
   input  logic                          i_push,
   input  logic [SIZE_DATA-1:0]          i_data,
   input  logic                          i_pop,
   output logic [SIZE_DATA-1:0]          o_data,
   output logic [clog2(BUF_DEPTH+1)-1:0] o_level
);
   localparam int IW = clog2(BUF_DEPTH);
   localparam int LW = clog2(BUF_DEPTH + 1);
   logic [SIZE_DATA-1:0] r_mem [BUF_DEPTH];
   logic [SIZE_DATA-1:0] r_hold;
   logic [IW-1:0]        r_rd, r_wr;
   logic [LW-1:0]        r_level;
   logic [IW-1:0]        w_rd_nxt, w_wr_nxt;
   // explicit wrap so non-power-of-2 depths stay in range
   assign w_rd_nxt = (r_rd == IW'(BUF_DEPTH - 1)) ? '0 : r_rd + IW'(1);
   assign w_wr_nxt = (r_wr == IW'(BUF_DEPTH - 1)) ? '0 : r_wr + IW'(1);
   // r_hold keeps the last presented word so o_data never shows stale slots
   assign o_data  = (r_level != '0) ? r_mem[r_rd] : r_hold;
   assign o_level = r_level;
   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wr] <= i_data;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hold  <= '0;
         r_rd    <= '0;
         r_wr    <= '0;
         r_level <= '0;
      end else begin
         r_hold <= o_data;
         if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_level <= '0;
         end else begin
            if (i_pop) r_rd <= w_rd_nxt;
            if (i_push) r_wr <= w_wr_nxt;
            r_level <= r_level + LW'(i_push) - LW'(i_pop);
         end
      end
   end
endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter: turns a 1-cycle-latency FIFO read port into a valid/ready stream
//  i_clk, i_rst_n              clock, async active-low reset
//  i_flush                     drop buffered words and any in-flight read
//  o_fifo_rd_en, i_fifo_empty  FIFO read strobe / empty flag
//  i_fifo_data                 FIFO data, valid the cycle after o_fifo_rd_en
//  o_valid, i_ready, o_data    output stream
//  o_level                     words currently buffered
module fifo_rd_stream_adapter
   import fifo_pkg::*;
#(
   parameter int SIZE_DATA = 8,
   parameter int BUF_DEPTH = 2
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_flush,
   output logic                          o_fifo_rd_en,
   input  logic                          i_fifo_empty,
   input  logic [SIZE_DATA-1:0]          i_fifo_data,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [SIZE_DATA-1:0]          o_data,
   output logic [clog2(BUF_DEPTH+1)-1:0] o_level
);
   localparam int LW = clog2(BUF_DEPTH + 1);
   localparam int CW = LW + 1;
   logic          r_inflight;
   logic          w_pop, w_push;
   logic [CW-1:0] w_committed;
   assign w_pop  = o_valid & i_ready;
   // a word landing during flush belongs to the discarded stream
   assign w_push = r_inflight & ~i_flush;
   // slots already spoken for after this cycle's pop; reading only when one is free
   // means the buffer cannot overflow, at the cost of an i_ready -> rd_en path
   assign w_committed  = {1'b0, o_level} + CW'(r_inflight) - CW'(w_pop);
   assign o_fifo_rd_en = i_rst_n & ~i_fifo_empty & ~i_flush & (w_committed < CW'(BUF_DEPTH));
   assign o_valid      = (o_level != '0);
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_inflight <= 1'b0;
      else r_inflight <= o_fifo_rd_en;
   end
   stream_buf #(
      .SIZE_DATA(SIZE_DATA),
      .BUF_DEPTH(BUF_DEPTH)
   ) u_buf (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_flush(i_flush),
      .i_push (w_push),
      .i_data (i_fifo_data),
      .i_pop  (w_pop),
      .o_data (o_data),
      .o_level(o_level)
   );
endmodule
